// File: rtl/vga_fetch_sched_if.sv
// Frame-buffer read request channel from the fetch scheduler to the DMA.
interface vga_fetch_sched_if #(
    parameter int LEN_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [LEN_W-1:0] req_len;

    modport master (
        output req_valid,
        output req_addr,
        output req_len,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_len,
        output req_ready
    );
endinterface

// File: rtl/vga_fetch_sched.sv
// Pixel-domain prefetch scheduler: issues credit-limited burst reads so the
// pixel FIFO never overflows, restarting at each frame boundary.
module vga_fetch_sched #(
    parameter int          HDISP      = 800,
    parameter int          VDISP      = 480,
    parameter int          BURST      = 16,
    parameter int          FIFO_DEPTH = 256,
    parameter logic [31:0] FB_BASE    = 32'h0
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              pix_pop,
    input  logic              data_push,
    vga_fetch_sched_if.master req,
    output logic              fifo_flush,
    output logic              frame_done,
    output logic              underflow,
    output logic              busy
);
    localparam int TOTAL = HDISP * VDISP;
    localparam int LW    = $clog2(BURST + 1);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int RW    = $clog2(TOTAL + 1);
    localparam int SW    = CW + 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t        state, state_n;
    logic          stop, stop_n;
    logic [CW-1:0] level, level_n;
    logic [CW-1:0] outstanding, outstanding_n;
    logic [RW-1:0] remaining, remaining_n;
    logic [31:0]   ptr, ptr_n;
    logic          req_valid_n;
    logic [31:0]   req_addr_n;
    logic [LW-1:0] req_len_n;
    logic          flush_n, done_n, underflow_n;
    logic          hs, restart, credit_ok;
    logic [LW-1:0] len;
    logic [SW-1:0] credits;

    assign hs  = req.req_valid && req.req_ready;
    assign len = (remaining >= RW'(BURST)) ? LW'(BURST)
                                           : LW'(remaining);
    assign credits = SW'(level) + SW'(outstanding) + SW'(len);
    assign credit_ok = (credits <= SW'(FIFO_DEPTH));

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        stop_n        = stop;
        restart       = 1'b0;
        flush_n       = 1'b0;
        done_n        = 1'b0;
        level_n       = level;
        underflow_n   = underflow;
        outstanding_n = outstanding;
        remaining_n   = remaining;
        ptr_n         = ptr;
        req_valid_n   = req.req_valid;
        req_addr_n    = req.req_addr;
        req_len_n     = req.req_len;

        // Occupancy: push and pop together cancel; pop on empty is an underflow.
        if (data_push && !pix_pop) begin
            if (level != CW'(FIFO_DEPTH)) level_n = level + CW'(1);
        end else if (pix_pop && !data_push) begin
            if (level != '0) level_n = level - CW'(1);
            else underflow_n = 1'b1;
        end

        if (hs) begin
            outstanding_n = outstanding_n + CW'(req.req_len);
            remaining_n   = remaining - RW'(req.req_len);
            ptr_n         = ptr + (32'(req.req_len) << 2);
        end
        if (data_push && outstanding != '0) begin
            outstanding_n = outstanding_n - CW'(1);
        end

        unique case (state)
            IDLE: begin
                if (enable && frame_start) begin
                    state_n = FETCH;
                    restart = 1'b1;
                end
            end
            FETCH: begin
                if (!enable) begin
                    state_n = DRAIN;
                    stop_n  = 1'b1;
                end else if (frame_start) begin
                    if (outstanding == '0 && !req.req_valid) begin
                        restart = 1'b1;
                    end else begin
                        state_n = DRAIN;
                        stop_n  = 1'b0;
                    end
                end else if (remaining_n == '0 && outstanding_n == '0) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                if (enable && frame_start) stop_n = 1'b0;
                else if (!enable) stop_n = 1'b1;
                if (outstanding == '0 && !req.req_valid) begin
                    if (stop_n) begin
                        state_n = IDLE;
                        flush_n = 1'b1;
                    end else begin
                        state_n = FETCH;
                        restart = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (restart) begin
            flush_n     = 1'b1;
            level_n     = '0;
            ptr_n       = FB_BASE;
            remaining_n = RW'(TOTAL);
            underflow_n = 1'b0;
        end

        // A new request waits one cycle after a handshake so counters settle.
        if (hs) begin
            req_valid_n = 1'b0;
        end else if (!req.req_valid && state == FETCH && state_n == FETCH &&
                     !restart && remaining != '0 && credit_ok) begin
            req_valid_n = 1'b1;
            req_addr_n  = ptr;
            req_len_n   = len;
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            stop          <= 1'b0;
            level         <= '0;
            outstanding   <= '0;
            remaining     <= '0;
            ptr           <= '0;
            req.req_valid <= 1'b0;
            req.req_addr  <= FB_BASE;
            req.req_len   <= '0;
            fifo_flush    <= 1'b0;
            frame_done    <= 1'b0;
            underflow     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            stop          <= stop_n;
            level         <= level_n;
            outstanding   <= outstanding_n;
            remaining     <= remaining_n;
            ptr           <= ptr_n;
            req.req_valid <= req_valid_n;
            req.req_addr  <= req_addr_n;
            req.req_len   <= req_len_n;
            fifo_flush    <= flush_n;
            frame_done    <= done_n;
            underflow     <= underflow_n;
            busy          <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_vga_fetch_sched.sv
// Directed and randomized bench for vga_fetch_sched with a transaction-level
// frame model (requested pixels, FIFO level, in-flight pixels).
module tb_vga_fetch_sched;
  localparam int HD = 22;
  localparam int VD = 4;
  localparam int BU = 16;
  localparam int DEP = 64;
  localparam int TOTAL = HD * VD;
  localparam int LW = $clog2(BU + 1);
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic pixel_clk = 1'b0;
  logic pixel_rst = 1'b1;
  logic enable = 1'b0;
  logic frame_start = 1'b0;
  logic pix_pop = 1'b0;
  logic data_push = 1'b0;
  logic fifo_flush, frame_done, underflow, busy;

  vga_fetch_sched_if #(.LEN_W(LW)) req_if ();

  vga_fetch_sched #(
    .HDISP(HD), .VDISP(VD), .BURST(BU),
    .FIFO_DEPTH(DEP), .FB_BASE(BASE)
  ) dut (
    .pixel_clk(pixel_clk),
    .pixel_rst(pixel_rst),
    .enable(enable),
    .frame_start(frame_start),
    .pix_pop(pix_pop),
    .data_push(data_push),
    .req(req_if),
    .fifo_flush(fifo_flush),
    .frame_done(frame_done),
    .underflow(underflow),
    .busy(busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  int tests = 0;
  int fails = 0;

  bit mon = 1'b0;
  int m_req, m_out, m_level;
  bit m_uf, m_active, e_flush, e_done;
  bit p_valid, p_ready;
  logic [31:0] p_addr;
  logic [LW-1:0] p_len;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare against what earlier cycles imply, then fold in this cycle.
  task automatic model_step();
    int len;
    chk("mon_flush", fifo_flush, e_flush);
    chk("mon_done", frame_done, e_done);
    chk("mon_uf", underflow, m_uf);
    if (!m_active) chk("mon_quiet", req_if.req_valid, 0);
    if (p_valid && !p_ready)
      chk("mon_hold",
          {req_if.req_valid, req_if.req_addr, req_if.req_len},
          {1'b1, p_addr, p_len});
    p_valid = req_if.req_valid;
    p_ready = req_if.req_ready;
    p_addr = req_if.req_addr;
    p_len = req_if.req_len;
    e_flush = 1'b0;
    e_done = 1'b0;
    if (enable && frame_start && !m_active) begin
      m_active = 1'b1;
      m_req = 0;
      m_level = 0;
      m_uf = 1'b0;
      e_flush = 1'b1;
    end else begin
      if (req_if.req_valid && req_if.req_ready) begin
        len = (TOTAL - m_req < BU) ? TOTAL - m_req : BU;
        chk("mon_addr", req_if.req_addr, BASE + 4 * m_req);
        chk("mon_len", req_if.req_len, len);
        chk("mon_credit", m_level + m_out + len <= DEP, 1);
        m_req += len;
        m_out += len;
      end
      if (data_push && m_out > 0) begin
        m_out--;
        if (m_active && m_req == TOTAL && m_out == 0) begin
          e_done = 1'b1;
          m_active = 1'b0;
        end
      end
      if (data_push && !pix_pop) begin
        if (m_level < DEP) m_level++;
      end else if (pix_pop && !data_push) begin
        if (m_level > 0) m_level--;
        else m_uf = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge pixel_clk);
    if (mon) model_step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic do_reset();
    mon = 1'b0;
    enable = 1'b0;
    frame_start = 1'b0;
    pix_pop = 1'b0;
    data_push = 1'b0;
    req_if.req_ready = 1'b0;
    pixel_rst = 1'b1;
    tick();
    tick();
    pixel_rst = 1'b0;
    tick();
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    int nreq, dma, hs_len, n;
    bit last_push, done_seen;

    // Reset state
    do_reset();
    for (int i = 0; i < 100; i++) begin
      chk("reset_idle",
          {req_if.req_valid, fifo_flush, frame_done, underflow, busy,
           req_if.req_addr, req_if.req_len},
          {5'b0, BASE, LW'(0)});
      tick();
    end

    // Credit limit: four bursts fill the 64-pixel budget
    do_reset();
    enable = 1'b1;
    req_if.req_ready = 1'b1;
    start_frame();
    chk("cr_flush", {fifo_flush, req_if.req_valid}, 2'b10);
    nreq = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_if.req_valid) begin
        chk("cr_addr", req_if.req_addr, BASE + 64 * nreq);
        chk("cr_len", req_if.req_len, 16);
        nreq++;
      end
      tick();
    end
    chk("cr_count", nreq, 4);
    data_push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("cr_stall_push", req_if.req_valid, 0);
    end
    data_push = 1'b0;
    pix_pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("cr_stall_pop", req_if.req_valid, 0);
    end
    pix_pop = 1'b0;
    tick();
    chk("cr_fifth",
        {req_if.req_valid, req_if.req_addr, req_if.req_len},
        {1'b1, BASE + 32'd256, LW'(16)});

    // Backpressure holds the request stable
    do_reset();
    enable = 1'b1;
    start_frame();
    tick();
    for (int i = 0; i < 11; i++) begin
      chk("bp_hold",
          {req_if.req_valid, req_if.req_addr, req_if.req_len},
          {1'b1, BASE, LW'(16)});
      tick();
    end
    req_if.req_ready = 1'b1;
    tick();
    chk("bp_drop", req_if.req_valid, 0);
    tick();
    chk("bp_next",
        {req_if.req_valid, req_if.req_addr, req_if.req_len},
        {1'b1, BASE + 32'd64, LW'(16)});
    pixel_rst = 1'b1;
    #1;
    chk("async_rst",
        {req_if.req_valid, busy, req_if.req_addr, req_if.req_len},
        {2'b00, BASE, LW'(0)});

    // Underflow is sticky until the next restart
    do_reset();
    enable = 1'b1;
    pix_pop = 1'b1;
    tick();
    pix_pop = 1'b0;
    chk("uf_set", underflow, 1);
    tick();
    tick();
    chk("uf_sticky", {underflow, busy}, 2'b10);
    start_frame();
    chk("uf_clear", {fifo_flush, underflow}, 2'b10);

    // Mid-frame restart drains in-flight data first
    do_reset();
    enable = 1'b1;
    req_if.req_ready = 1'b1;
    start_frame();
    tick();
    chk("mf_first", {req_if.req_valid, req_if.req_addr}, {1'b1, BASE});
    tick();
    start_frame();
    chk("mf_noreq", {req_if.req_valid, fifo_flush}, 2'b00);
    data_push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("mf_drain", {req_if.req_valid, fifo_flush}, 2'b00);
    end
    data_push = 1'b0;
    tick();
    chk("mf_flush", {fifo_flush, req_if.req_valid}, 2'b10);
    tick();
    chk("mf_restart",
        {req_if.req_valid, req_if.req_addr, req_if.req_len},
        {1'b1, BASE, LW'(16)});

    // Rest of that frame: partial last burst and frame_done timing
    nreq = 0;
    dma = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 400 && !done_seen; i++) begin
      hs_len = 0;
      if (req_if.req_valid) begin
        chk("pb_addr", req_if.req_addr, BASE + 64 * nreq);
        chk("pb_len", req_if.req_len, (nreq == 5) ? 8 : 16);
        hs_len = int'(req_if.req_len);
        nreq++;
      end
      data_push = (dma > 0);
      pix_pop = data_push;
      if (data_push) dma--;
      last_push = data_push && dma == 0 && hs_len == 0 && nreq == 6;
      dma += hs_len;
      tick();
      if (last_push) begin
        chk("pb_done", {frame_done, busy}, 2'b10);
        done_seen = 1'b1;
      end else begin
        chk("pb_nodone", frame_done, 0);
      end
    end
    data_push = 1'b0;
    pix_pop = 1'b0;
    chk("pb_reqs", nreq, 6);
    chk("pb_seen", done_seen, 1);
    tick();
    chk("pb_idle", {busy, frame_done, req_if.req_valid}, 3'b000);

    // Disable mid-frame: drain, flush, idle
    do_reset();
    enable = 1'b1;
    req_if.req_ready = 1'b1;
    start_frame();
    tick();
    tick();
    enable = 1'b0;
    tick();
    chk("dis_drain", {req_if.req_valid, busy}, 2'b01);
    data_push = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    data_push = 1'b0;
    tick();
    chk("dis_flush", {fifo_flush, busy, req_if.req_valid}, 3'b100);
    tick();
    chk("dis_idle", {fifo_flush, busy}, 2'b00);

    // Randomized frames against the model
    do_reset();
    enable = 1'b1;
    m_req = 0;
    m_out = 0;
    m_level = 0;
    m_uf = 1'b0;
    m_active = 1'b0;
    e_flush = 1'b0;
    e_done = 1'b0;
    p_valid = 1'b0;
    p_ready = 1'b0;
    p_addr = BASE;
    p_len = '0;
    mon = 1'b1;
    for (int f = 0; f < 2; f++) begin
      start_frame();
      dma = 0;
      n = 0;
      while (m_active && n < 3000) begin
        req_if.req_ready = ($urandom_range(0, 2) != 0);
        hs_len = (req_if.req_valid && req_if.req_ready)
                 ? int'(req_if.req_len) : 0;
        data_push = (dma > 0) && ($urandom_range(0, 3) != 0);
        if (data_push) dma--;
        pix_pop = ($urandom_range(0, 1) == 1);
        dma += hs_len;
        tick();
        n++;
      end
      chk("rand_frame_end", m_active, 0);
      data_push = 1'b0;
      pix_pop = 1'b0;
      req_if.req_ready = 1'b0;
      tick();
      tick();
      chk("rand_idle", busy, 0);
    end
    mon = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_fetch_sched.md
# vga_fetch_sched

Frame-buffer prefetch scheduler for the VGA output path, clocked in the pixel domain. It sequences burst read requests to the frame-buffer DMA so the pixel FIFO feeding the video timing generator never overflows and rarely underflows. It tracks FIFO occupancy and in-flight data, generates linear frame addresses, restarts on each frame boundary and flags underflow.

## Interface
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- BURST, 16, maximum pixels per read request
- FIFO_DEPTH, 256, pixel FIFO capacity in pixels (≥ BURST)
- FB_BASE, 32'h0, byte address of pixel 0; 4 bytes per pixel

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge
- pixel_rst  in  1  reset, asynchronous, active-high
- enable  in  1  scheduler enable
- frame_start  in  1  1-cycle pulse, start of vertical blanking
- pix_pop  in  1  display consumed one pixel from the FIFO
- data_push  in  1  DMA wrote one pixel into the FIFO
- req_valid  out  1  read request valid
- req_ready  in  1  DMA accepts request
- req_addr  out  32  request byte address
- req_len  out  $clog2(BURST+1)  request length in pixels
- fifo_flush  out  1  1-cycle pulse, empty the pixel FIFO
- frame_done  out  1  1-cycle pulse, all frame pixels delivered
- underflow  out  1  sticky, pop seen with FIFO empty
- busy  out  1  state ≠ IDLE

## Operation
- Counters:
  - level: 0..FIFO_DEPTH pixels in the FIFO. +1 on data_push, −1 on pix_pop; both in the same cycle leave it unchanged.
  - outstanding: 0..FIFO_DEPTH pixels requested but not pushed. +req_len on handshake, −1 per data_push.
  - remaining: width $clog2(HDISP*VDISP+1), pixels not yet requested.
  - ptr: 32-bit next address.
- Credits = level + outstanding. A request is issued only if credits + req_len ≤ FIFO_DEPTH.
- req_len = min(BURST, remaining). The last burst may be partial.
- States:
  - IDLE: no requests. On enable && frame_start go to FETCH, taking the restart action.
  - FETCH: assert req_valid when remaining > 0 and the credit check passes.
    - On handshake (req_valid && req_ready): ptr += 4*req_len, remaining −= req_len, outstanding += req_len.
    - When remaining == 0 && outstanding == 0: pulse frame_done, go to IDLE.
    - On frame_start with outstanding == 0 and no pending request: restart in place.
    - On frame_start otherwise: go to DRAIN.
    - On !enable: go to DRAIN with a stop flag.
  - DRAIN: no new requests. A pending req_valid is held until its handshake, and that request counts as outstanding. Once outstanding == 0:
    - stop flag set → IDLE, with fifo_flush pulsed.
    - otherwise → FETCH, taking the restart action.
- Restart action (one cycle):
  - fifo_flush = 1
  - level = 0, ptr = FB_BASE, remaining = HDISP*VDISP
  - underflow cleared
- Underflow: pix_pop && level == 0 && !data_push sets underflow, and level stays 0. Underflow clears only on a restart.
- frame_start while !enable is ignored.
- Pushes while outstanding == 0 are illegal. The scheduler ignores them for the outstanding count; they still increment level up to a saturation of FIFO_DEPTH.

## Timing
- Reset values:
  - req_valid, fifo_flush, frame_done, underflow, busy: 0
  - req_addr = FB_BASE, req_len = 0
  - all counters 0, state IDLE
- All outputs are registered.
- Valid/ready rules:
  - Once req_valid = 1, it, req_addr and req_len are held until the cycle with req_ready = 1.
  - req_valid may re-assert the cycle after a handshake, so one request per 2 cycles at most.
- frame_start sampled in cycle N (IDLE, enable = 1, credits ok):
  - fifo_flush = 1 in N+1
  - req_valid = 1 with req_addr = FB_BASE in N+2
- Counter updates take effect the cycle after the event. The credit check uses registered values, so it is conservative by at most one cycle.
- frame_done is asserted the cycle after the last push is counted.
- pixel_rst mid-burst returns to the reset state immediately. The DMA must also be reset.

## Test plan
- Reset release with all inputs 0 → all outputs at reset values for 100 cycles; busy = 0.
- Credit limit: DEPTH = 64, BURST = 16, req_ready = 1, no pushes, frame_start → exactly 4 requests at addr 0, 64, 128, 192, each len 16. Then req_valid stays 0; 16 pushes and 16 pops → 5th request at addr 256.
- Backpressure: req_ready held 0 for 10 cycles → req_valid = 1, req_addr = 0, req_len = 16 stable throughout. Handshake on cycle 11, next request at addr 64.
- Underflow: enabled, level 0, one pix_pop → underflow = 1 next cycle and level stays 0. Next frame_start → fifo_flush pulse and underflow = 0.
- Mid-frame restart: frame_start with outstanding = 16 → no new request. After 16 pushes, fifo_flush pulses, then a request at addr FB_BASE with remaining reloaded.
- Partial burst: HDISP = 20, VDISP = 2, BURST = 16, immediate pushes → lens 16, 16, 8 at addr 0, 64, 128. frame_done one cycle after the 40th push, then IDLE.
